// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter slice.
package rf_wb_arbiter_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;
  typedef logic [REG_NUM-1:0]    reg_mask_t;

  // One regfile write: {we, waddr, wdata}.
  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;
  } rf_wb_bus_t;

  // r0 is hardwired to zero, so it never counts as a real destination or source.
  function automatic logic is_real_reg(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundles the WB, mul/div, issue, decode and regfile-side signals of the arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  // Pipeline writeback (port P)
  logic      p_we;
  reg_addr_t p_waddr;
  reg_data_t p_wdata;
  logic      p_hold;

  // Mul/div result (port L)
  logic      l_valid;
  reg_addr_t l_waddr;
  reg_data_t l_wdata;
  logic      l_ready;

  // Long-latency issue and decode hazard check
  logic      iss_valid;
  reg_addr_t iss_rd;
  reg_addr_t id_raddr1;
  reg_addr_t id_raddr2;
  logic      id_we;
  reg_addr_t id_waddr;
  logic      id_stall;

  // Regfile write port and debug view
  logic      rf_we;
  reg_addr_t rf_waddr;
  reg_data_t rf_wdata;
  reg_mask_t sb_busy;

  // Environment side: WB stage, mul/div unit, decode, regfile.
  modport master (
    output p_we, p_waddr, p_wdata,
    input  p_hold,
    output l_valid, l_waddr, l_wdata,
    input  l_ready,
    output iss_valid, iss_rd, id_raddr1, id_raddr2, id_we, id_waddr,
    input  id_stall,
    input  rf_we, rf_waddr, rf_wdata, sb_busy
  );

  // Arbiter side.
  modport slave (
    input  p_we, p_waddr, p_wdata,
    output p_hold,
    input  l_valid, l_waddr, l_wdata,
    output l_ready,
    input  iss_valid, iss_rd, id_raddr1, id_raddr2, id_we, id_waddr,
    output id_stall,
    output rf_we, rf_waddr, rf_wdata, sb_busy
  );

endinterface

// File: rtl/rf_wb_arbiter_wb_scoreboard.sv
// Busy vector of outstanding long-latency destinations and the decode hazard compare.
module wb_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  input  logic      rd_we,
  input  reg_addr_t waddr,
  output logic      stall,
  output reg_mask_t busy
);

  reg_mask_t set_mask;
  reg_mask_t clr_mask;

  // Decode one-hot set/clear masks; r0 never becomes busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && is_real_reg(set_addr)) set_mask[set_addr] = 1'b1;
    if (clr_en)                          clr_mask[clr_addr] = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Busy vector update; an issue wins over a commit to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~reg_mask_t'(1);
    end
  end

  // RAW on either source or WAW on the destination against an outstanding long op.
  always_comb begin
    stall = 1'b0;
    if (is_real_reg(raddr1) && busy[raddr1])        stall = 1'b1;
    if (is_real_reg(raddr2) && busy[raddr2])        stall = 1'b1;
    if (rd_we && is_real_reg(waddr) && busy[waddr]) stall = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single regfile write port between pipeline WB and the mul/div result path,
// buffering one mul/div result and bounding how long it can be starved by WB writes.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             buf_valid;
  reg_addr_t        buf_addr;
  reg_data_t        buf_data;
  logic [CNT_W-1:0] starve_cnt;

  logic       p_hold;
  logic       p_eff;
  logic       buf_commit;
  logic       accept;
  rf_wb_bus_t wr_bus;

  // The hold is a pure function of buffer state, so WB sees it early in the cycle.
  assign p_hold     = buf_valid && (starve_cnt == CNT_MAX);
  assign p_eff      = !rst && bus.p_we && is_real_reg(bus.p_waddr) && !p_hold;
  assign buf_commit = !rst && buf_valid && !p_eff;
  assign accept     = bus.l_valid && bus.l_ready;

  assign bus.p_hold  = p_hold;
  assign bus.l_ready = !rst && (!buf_valid || buf_commit);

  // Write-port mux: the buffer takes the port whenever WB is not really writing.
  always_comb begin
    wr_bus.we    = p_eff;
    wr_bus.waddr = bus.p_waddr;
    wr_bus.wdata = bus.p_wdata;
    if (buf_commit) begin
      wr_bus.we    = is_real_reg(buf_addr);
      wr_bus.waddr = buf_addr;
      wr_bus.wdata = buf_data;
    end
  end

  assign bus.rf_we    = wr_bus.we;
  assign bus.rf_waddr = wr_bus.waddr;
  assign bus.rf_wdata = wr_bus.wdata;

  // Buffer occupancy and starvation count; a commit and a new accept can overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      starve_cnt <= '0;
    end else if (accept) begin
      buf_valid  <= 1'b1;
      starve_cnt <= '0;
    end else if (buf_commit) begin
      buf_valid  <= 1'b0;
      starve_cnt <= '0;
    end else if (buf_valid && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Buffer payload is only meaningful while buf_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_addr <= bus.l_waddr;
      buf_data <= bus.l_wdata;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.iss_valid),
    .set_addr (bus.iss_rd),
    .clr_en   (buf_commit),
    .clr_addr (buf_addr),
    .raddr1   (bus.id_raddr1),
    .raddr2   (bus.id_raddr2),
    .rd_we    (bus.id_we),
    .waddr    (bus.id_waddr),
    .stall    (bus.id_stall),
    .busy     (bus.sb_busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected regfile writes are queued by the stimulus
// and checked in order by a monitor; control outputs are checked inline.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tb_rf [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every regfile write must match the next expected write.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(e.a));
        chk("wr_data", bus.rf_wdata, e.d);
      end
    end
  end

  // Regfile model fed by the write port.
  always @(posedge clk) begin
    if (bus.rf_we === 1'b1) tb_rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int cycles;
    logic exp_hold;

    for (int k = 0; k < 32; k++) tb_rf[k] = 32'h0;
    rst = 1'b1;
    bus.p_we = 1'b0;  bus.p_waddr = '0;  bus.p_wdata = '0;
    bus.l_valid = 1'b1; bus.l_waddr = 5'd3; bus.l_wdata = 32'h33;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.id_raddr1 = '0; bus.id_raddr2 = '0; bus.id_we = 1'b0; bus.id_waddr = '0;

    // Reset held two cycles with a pending mul/div result
    for (int r = 0; r < 2; r++) begin
      tick();
      @(negedge clk);
      chk("rst_l_ready", 32'(bus.l_ready), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_sb_busy", bus.sb_busy, 32'h0);
      chk("rst_p_hold", 32'(bus.p_hold), 32'd0);
      chk("rst_id_stall", 32'(bus.id_stall), 32'd0);
    end
    tick();
    rst = 1'b0;
    bus.l_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_l_ready", 32'(bus.l_ready), 32'd1);

    // P only
    tick();
    bus.p_we = 1'b1; bus.p_waddr = 5'd5; bus.p_wdata = 32'h1234;
    push(5'd5, 32'h1234);
    @(negedge clk);
    chk("p_rf_we", 32'(bus.rf_we), 32'd1);
    chk("p_rf_waddr", 32'(bus.rf_waddr), 32'd5);
    tick();
    bus.p_waddr = 5'd0; bus.p_wdata = 32'h55;
    @(negedge clk);
    chk("p_r0_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    bus.p_we = 1'b0;

    // Scoreboard round trip
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.id_raddr2 = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("sb_busy7", bus.sb_busy, 32'h0000_0080);
    chk("stall_raw2", 32'(bus.id_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("stall_raw2_c2", 32'(bus.id_stall), 32'd1);
    tick();
    bus.id_raddr2 = 5'd0; bus.id_we = 1'b1; bus.id_waddr = 5'd7;
    @(negedge clk);
    chk("stall_waw", 32'(bus.id_stall), 32'd1);
    tick();
    bus.id_we = 1'b0; bus.id_raddr1 = 5'd7;
    bus.l_valid = 1'b1; bus.l_waddr = 5'd7; bus.l_wdata = 32'hCAFE;
    push(5'd7, 32'hCAFE);
    @(negedge clk);
    chk("rt_l_ready", 32'(bus.l_ready), 32'd1);
    chk("stall_raw1", 32'(bus.id_stall), 32'd1);
    tick();
    bus.l_valid = 1'b0;
    @(negedge clk);
    chk("rt_commit_rf_we", 32'(bus.rf_we), 32'd1);
    chk("rt_stall_commit_cycle", 32'(bus.id_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("rt_stall_cleared", 32'(bus.id_stall), 32'd0);
    chk("rt_sb_busy_clear", bus.sb_busy, 32'h0);
    chk("rt_regfile_r7", tb_rf[7], 32'hCAFE);
    tick();
    bus.id_raddr1 = 5'd0;

    // Starvation: P writes r1..r8 back to back while r12 sits in the buffer
    i = 1;
    cycles = 0;
    while (i <= 8) begin
      bus.p_we = 1'b1; bus.p_waddr = 5'(i); bus.p_wdata = 32'h100 + 32'(i);
      bus.l_valid = (cycles == 0); bus.l_waddr = 5'd12; bus.l_wdata = 32'hBEEF;
      exp_hold = (cycles == 4);
      if (exp_hold) push(5'd12, 32'hBEEF);
      else          push(5'(i), 32'h100 + 32'(i));
      @(negedge clk);
      chk("starve_p_hold", 32'(bus.p_hold), 32'(exp_hold));
      if (!exp_hold) i++;
      tick();
      cycles++;
    end
    bus.p_we = 1'b0; bus.l_valid = 1'b0;

    // Back-to-back L results with P idle
    for (int k = 0; k < 4; k++) begin
      bus.l_valid = 1'b1; bus.l_waddr = 5'(20 + k); bus.l_wdata = 32'hA0 + 32'(k);
      push(5'(20 + k), 32'hA0 + 32'(k));
      @(negedge clk);
      chk("b2b_l_ready", 32'(bus.l_ready), 32'd1);
      chk("b2b_rf_we", 32'(bus.rf_we), 32'(k > 0));
      tick();
    end
    bus.l_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_rf_we", 32'(bus.rf_we), 32'd1);
    tick();

    // Set/clear collision on r9
    bus.l_valid = 1'b1; bus.l_waddr = 5'd9; bus.l_wdata = 32'h999;
    push(5'd9, 32'h999);
    tick();
    bus.l_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    @(negedge clk);
    chk("coll_rf_we", 32'(bus.rf_we), 32'd1);
    tick();
    bus.iss_valid = 1'b0; bus.id_raddr1 = 5'd9;
    @(negedge clk);
    chk("coll_busy9", bus.sb_busy, 32'h0000_0200);
    chk("coll_stall", 32'(bus.id_stall), 32'd1);
    tick();
    bus.id_raddr1 = 5'd0;

    // Reset mid-operation with a buffered result and busy bits
    bus.p_we = 1'b1; bus.p_waddr = 5'd2; bus.p_wdata = 32'h202;
    bus.l_valid = 1'b1; bus.l_waddr = 5'd15; bus.l_wdata = 32'hF00D;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd20;
    push(5'd2, 32'h202);
    tick();
    rst = 1'b1;
    bus.p_we = 1'b0; bus.l_valid = 1'b0; bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("midrst_l_ready", 32'(bus.l_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sb_busy", bus.sb_busy, 32'h0);
    chk("midrst_no_buf_write", 32'(bus.rf_we), 32'd0);
    chk("midrst_l_ready_after", 32'(bus.l_ready), 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
